// File: rtl/imem_loader_readback_pkg.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader_readback_pkg
// Purpose  : Shared types and constants for the instruction-memory loader and
//            register-file / data-memory byte readback port.
// Revision : 1.0 - initial release
// ============================================================================
package imem_loader_readback_pkg;

  // Loader FSM states
  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    FLUSH = 2'd1,
    RUN   = 2'd2,
    FULL  = 2'd3
  } state_t;

  // Readback source select
  localparam logic RD_SEL_DMEM = 1'b0;
  localparam logic RD_SEL_REG  = 1'b1;

  // Default instruction word width
  localparam int XLEN_DEFAULT = 32;

  // Index width for n items, never narrower than one bit
  function automatic int safe_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/imem_loader_readback_byte_lane_packer.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader_readback_byte_lane_packer
// Purpose  : Packs a byte stream little-endian into XLEN-bit words. Presents
//            a combinational word-complete strobe with the finished word on
//            the cycle the closing byte (or a flushing byte) is accepted.
// Revision : 1.0 - initial release
// ============================================================================
module imem_loader_readback_byte_lane_packer
  import imem_loader_readback_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            byte_en,
  input  logic [7:0]      byte_in,
  input  logic            flush,
  output logic            word_valid,
  output logic [XLEN-1:0] word
);

  localparam int LANES  = XLEN / 8;
  localparam int LANE_W = safe_clog2(LANES);

  logic [LANE_W-1:0] lane_q, lane_d;
  logic [XLEN-1:0]   pack_q, pack_d;
  logic [XLEN-1:0]   merged;

  // Insert the incoming byte into its lane on top of the bytes gathered so far
  always_comb begin
    merged = pack_q;
    for (int i = 0; i < LANES; i++) begin
      if (lane_q == LANE_W'(i)) begin
        merged[8*i +: 8] = byte_in;
      end
    end
  end

  // Lanes above the current one are always zero in pack_q (it is cleared
  // after every word), so a flushed partial word is already zero-padded.
  assign word_valid = byte_en && (flush || (lane_q == LANE_W'(LANES - 1)));
  assign word       = merged;

  // Advance the lane, or restart packing once a word has been handed out
  always_comb begin
    lane_d = lane_q;
    pack_d = pack_q;
    if (word_valid) begin
      lane_d = '0;
      pack_d = '0;
    end else if (byte_en) begin
      lane_d = lane_q + LANE_W'(1);
      pack_d = merged;
    end
  end

  // Packing state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      lane_q <= '0;
      pack_q <= '0;
    end else begin
      lane_q <= lane_d;
      pack_q <= pack_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/imem_loader_readback.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader_readback
// Purpose  : Host bring-up port. Loads a byte-serial program into instruction
//            memory with a valid/ready handshake, releases the core, and
//            offers a pipelined 2-cycle byte readback of the register file or
//            data memory.
// Revision : 1.0 - initial release
// ============================================================================
module imem_loader_readback
  import imem_loader_readback_pkg::*;
#(
  parameter  int XLEN       = XLEN_DEFAULT,
  parameter  int IMEM_DEPTH = 64,
  parameter  int ADDR_W     = 11,
  parameter  int REG_ADDR_W = 5,
  localparam int LANES      = XLEN / 8,
  localparam int LANE_W     = safe_clog2(LANES),
  localparam int IA_W       = safe_clog2(IMEM_DEPTH)
) (
  input  logic                  sys_clk,
  input  logic                  sys_reset,
  input  logic                  load_valid,
  input  logic [7:0]            load_byte,
  input  logic                  load_last,
  output logic                  load_ready,
  output logic                  imem_we,
  output logic [IA_W-1:0]       imem_waddr,
  output logic [XLEN-1:0]       imem_wdata,
  output logic                  cpu_run,
  output logic                  load_err,
  input  logic                  rd_req,
  input  logic                  rd_sel,
  input  logic [ADDR_W-1:0]     rd_addr,
  input  logic [LANE_W-1:0]     rd_lane,
  output logic [REG_ADDR_W-1:0] reg_raddr,
  output logic [ADDR_W-1:0]     dmem_raddr,
  input  logic [XLEN-1:0]       reg_rdata,
  input  logic [XLEN-1:0]       dmem_rdata,
  output logic                  rd_valid,
  output logic [7:0]            value_o
);

  // One extra bit so the pointer can reach IMEM_DEPTH (memory full)
  localparam int PTR_W = IA_W + 1;

  // ---------------------------------------------------------------- loader
  state_t            state_q, state_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic              load_ready_q, load_ready_d;
  logic              imem_we_q, imem_we_d;
  logic [IA_W-1:0]   imem_waddr_q, imem_waddr_d;
  logic [XLEN-1:0]   imem_wdata_q, imem_wdata_d;
  logic              cpu_run_q, cpu_run_d;
  logic              load_err_q, load_err_d;

  logic              accept;
  logic              ptr_full;
  logic              overflow;
  logic              pack_en;
  logic              word_valid;
  logic [XLEN-1:0]   word;

  assign accept   = load_valid && load_ready_q;
  assign ptr_full = (ptr_q == PTR_W'(IMEM_DEPTH));
  assign overflow = accept && ptr_full;
  assign pack_en  = accept && !ptr_full;

  imem_loader_readback_byte_lane_packer #(
    .XLEN (XLEN)
  ) u_packer (
    .clk        (sys_clk),
    .rst        (sys_reset),
    .byte_en    (pack_en),
    .byte_in    (load_byte),
    .flush      (load_last),
    .word_valid (word_valid),
    .word       (word)
  );

  // Loader next-state: pack, write completed words, flush, release or lock up
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    imem_we_d    = 1'b0;
    imem_waddr_d = imem_waddr_q;
    imem_wdata_d = imem_wdata_q;
    load_err_d   = load_err_q;
    case (state_q)
      LOAD: begin
        if (overflow) begin
          // Byte dropped; an overflowing last byte also lands here
          load_err_d = 1'b1;
          state_d    = FULL;
        end else if (pack_en) begin
          if (word_valid) begin
            imem_we_d    = 1'b1;
            imem_waddr_d = ptr_q[IA_W-1:0];
            imem_wdata_d = word;
            ptr_d        = ptr_q + PTR_W'(1);
          end
          if (load_last) begin
            state_d = FLUSH;
          end
        end
      end
      // The final (full or zero-padded) word is on the write port this
      // cycle, so the core can be released next
      FLUSH:   state_d    = RUN;
      RUN:     state_d    = RUN;
      FULL:    load_err_d = 1'b1;
      default: state_d    = LOAD;
    endcase
    load_ready_d = (state_d == LOAD);
    cpu_run_d    = (state_q == RUN);
  end

  // Loader FSM and its registered outputs
  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      state_q      <= LOAD;
      ptr_q        <= '0;
      load_ready_q <= 1'b1;
      imem_we_q    <= 1'b0;
      imem_waddr_q <= '0;
      imem_wdata_q <= '0;
      cpu_run_q    <= 1'b0;
      load_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      load_ready_q <= load_ready_d;
      imem_we_q    <= imem_we_d;
      imem_waddr_q <= imem_waddr_d;
      imem_wdata_q <= imem_wdata_d;
      cpu_run_q    <= cpu_run_d;
      load_err_q   <= load_err_d;
    end
  end

  assign load_ready = load_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_waddr = imem_waddr_q;
  assign imem_wdata = imem_wdata_q;
  assign cpu_run    = cpu_run_q;
  assign load_err   = load_err_q;

  // -------------------------------------------------------------- readback
  // Stage 1 holds the sampled request and drives the read addresses; stage 2
  // tracks the request while the memories return data; value_o registers it.
  logic              req1_q, req1_d;
  logic              sel1_q, sel1_d;
  logic [ADDR_W-1:0] addr1_q, addr1_d;
  logic [LANE_W-1:0] lane1_q, lane1_d;
  logic              req2_q, req2_d;
  logic              sel2_q, sel2_d;
  logic [LANE_W-1:0] lane2_q, lane2_d;
  logic              rd_valid_q, rd_valid_d;
  logic [7:0]        value_q, value_d;
  logic [XLEN-1:0]   rb_word;
  logic [7:0]        rb_byte;

  assign rb_word = (sel2_q == RD_SEL_REG) ? reg_rdata : dmem_rdata;

  // Readback pipeline next-state and byte-lane selection
  always_comb begin
    req1_d  = rd_req;
    sel1_d  = rd_req ? rd_sel  : sel1_q;
    addr1_d = rd_req ? rd_addr : addr1_q;
    lane1_d = rd_req ? rd_lane : lane1_q;
    req2_d  = req1_q;
    sel2_d  = req1_q ? sel1_q  : sel2_q;
    lane2_d = req1_q ? lane1_q : lane2_q;
    rb_byte = 8'h00;
    for (int i = 0; i < LANES; i++) begin
      if (lane2_q == LANE_W'(i)) begin
        rb_byte = rb_word[8*i +: 8];
      end
    end
    rd_valid_d = req2_q;
    value_d    = req2_q ? rb_byte : value_q;
  end

  // Readback pipeline registers
  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      req1_q     <= 1'b0;
      sel1_q     <= 1'b0;
      addr1_q    <= '0;
      lane1_q    <= '0;
      req2_q     <= 1'b0;
      sel2_q     <= 1'b0;
      lane2_q    <= '0;
      rd_valid_q <= 1'b0;
      value_q    <= 8'h00;
    end else begin
      req1_q     <= req1_d;
      sel1_q     <= sel1_d;
      addr1_q    <= addr1_d;
      lane1_q    <= lane1_d;
      req2_q     <= req2_d;
      sel2_q     <= sel2_d;
      lane2_q    <= lane2_d;
      rd_valid_q <= rd_valid_d;
      value_q    <= value_d;
    end
  end

  assign reg_raddr  = addr1_q[REG_ADDR_W-1:0];
  assign dmem_raddr = addr1_q;
  assign rd_valid   = rd_valid_q;
  assign value_o    = value_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader_readback.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_loader_readback
// Purpose  : Self-checking bench for imem_loader_readback (IMEM_DEPTH = 4).
//            Stimulus pushes expected writes / readback bytes into queues; a
//            negedge monitor pops and compares whenever the DUT presents one.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_imem_loader_readback;

  logic        sys_clk = 1'b0;
  logic        sys_reset = 1'b1;
  logic        load_valid = 1'b0;
  logic [7:0]  load_byte = 8'h00;
  logic        load_last = 1'b0;
  logic        load_ready;
  logic        imem_we;
  logic [1:0]  imem_waddr;
  logic [31:0] imem_wdata;
  logic        cpu_run;
  logic        load_err;
  logic        rd_req = 1'b0;
  logic        rd_sel = 1'b0;
  logic [10:0] rd_addr = 11'd0;
  logic [1:0]  rd_lane = 2'd0;
  logic [4:0]  reg_raddr;
  logic [10:0] dmem_raddr;
  logic [31:0] reg_rdata = 32'd0;
  logic [31:0] dmem_rdata = 32'd0;
  logic        rd_valid;
  logic [7:0]  value_o;

  imem_loader_readback #(
    .XLEN       (32),
    .IMEM_DEPTH (4),
    .ADDR_W     (11),
    .REG_ADDR_W (5)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_reset  (sys_reset),
    .load_valid (load_valid),
    .load_byte  (load_byte),
    .load_last  (load_last),
    .load_ready (load_ready),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .cpu_run    (cpu_run),
    .load_err   (load_err),
    .rd_req     (rd_req),
    .rd_sel     (rd_sel),
    .rd_addr    (rd_addr),
    .rd_lane    (rd_lane),
    .reg_raddr  (reg_raddr),
    .dmem_raddr (dmem_raddr),
    .reg_rdata  (reg_rdata),
    .dmem_rdata (dmem_rdata),
    .rd_valid   (rd_valid),
    .value_o    (value_o)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // Synchronous-read memory models: data one cycle after the address
  always @(posedge sys_clk) begin
    reg_rdata  <= (reg_raddr == 5'd5) ? 32'hDEADBEEF : {27'd0, reg_raddr};
    dmem_rdata <= (dmem_raddr == 11'h010) ? 32'h12345678 : {21'd0, dmem_raddr};
  end

  int          n_checks = 0;
  int          n_fail   = 0;
  int          exp_wa[$];
  logic [31:0] exp_wd[$];
  logic [7:0]  exp_rv[$];
  int          exp_rc[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor
  always @(negedge sys_clk) begin
    int          a;
    logic [31:0] d;
    int          c;
    logic [7:0]  v;
    if (imem_we === 1'b1) begin
      if (exp_wa.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got waddr %0d wdata 0x%h, required no write", imem_waddr, imem_wdata);
      end else begin
        a = exp_wa.pop_front();
        d = exp_wd.pop_front();
        check("imem_waddr", 32'(imem_waddr), 32'(a));
        check("imem_wdata", imem_wdata, d);
      end
    end
    if (rd_valid === 1'b1) begin
      if (exp_rv.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_rd_valid: got value_o 0x%h, required no pulse", value_o);
      end else begin
        v = exp_rv.pop_front();
        c = exp_rc.pop_front();
        check("value_o", 32'(value_o), 32'(v));
        check("rd_latency_cycle", 32'(cyc), 32'(c));
      end
    end
  end

  task automatic do_reset(input bit with_req);
    sys_reset = 1'b1;
    load_valid = 1'b0;
    load_last = 1'b0;
    rd_req = with_req;
    rd_sel = 1'b1;
    rd_addr = 11'd5;
    rd_lane = 2'd0;
    @(posedge sys_clk);
    @(posedge sys_clk);
    #1;
    sys_reset = 1'b0;
    rd_req = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit last);
    load_valid = 1'b1;
    load_byte = b;
    load_last = last;
    @(posedge sys_clk);
    #1;
    load_valid = 1'b0;
    load_last = 1'b0;
    load_byte = 8'h00;
  endtask

  task automatic push_wr(input int a, input logic [31:0] d);
    exp_wa.push_back(a);
    exp_wd.push_back(d);
  endtask

  // dmem readback of 0x10 lane 1: address on the port one cycle after request
  task automatic rd_dmem_check();
    rd_req = 1'b1;
    rd_sel = 1'b0;
    rd_addr = 11'h010;
    rd_lane = 2'd1;
    @(posedge sys_clk);
    #1;
    rd_req = 1'b0;
    exp_rv.push_back(8'h56);
    exp_rc.push_back(cyc + 2);
    check("dmem_raddr", 32'(dmem_raddr), 32'h10);
    idle(4);
    check("rd_queue_drained", 32'(exp_rv.size()), 32'd0);
  endtask

  logic [7:0] prog1[8] = '{8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'hB0, 8'h00};
  logic [7:0] prog2[6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
  logic [7:0] reg_exp[4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};

  initial begin
    // Reset state; a readback request held during reset must be discarded
    do_reset(1'b1);
    check("rst_load_ready", 32'(load_ready), 32'd1);
    check("rst_imem_we", 32'(imem_we), 32'd0);
    check("rst_imem_waddr", 32'(imem_waddr), 32'd0);
    check("rst_imem_wdata", imem_wdata, 32'd0);
    check("rst_cpu_run", 32'(cpu_run), 32'd0);
    check("rst_load_err", 32'(load_err), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_value_o", 32'(value_o), 32'd0);

    // Two full words back to back, last on the 8th byte
    push_wr(0, 32'h00A00513);
    push_wr(1, 32'h00B00593);
    for (int i = 0; i < 8; i++) send_byte(prog1[i], i == 7);
    check("t1_last_write_now", 32'(imem_we), 32'd1);
    idle(1);
    check("t1_cpu_run_early", 32'(cpu_run), 32'd0);
    check("t1_load_ready_flush", 32'(load_ready), 32'd0);
    check("t1_writes_done", 32'(exp_wa.size()), 32'd0);
    idle(1);
    check("t1_cpu_run", 32'(cpu_run), 32'd1);
    check("t1_load_err", 32'(load_err), 32'd0);

    // In RUN: load_valid ignored, pipelined register readback of x5
    load_valid = 1'b1;
    load_byte = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      rd_req = 1'b1;
      rd_sel = 1'b1;
      rd_addr = 11'd5;
      rd_lane = 2'(3 - i);
      @(posedge sys_clk);
      #1;
      exp_rv.push_back(reg_exp[i]);
      exp_rc.push_back(cyc + 2);
      if (i == 0) check("reg_raddr", 32'(reg_raddr), 32'd5);
    end
    rd_req = 1'b0;
    load_valid = 1'b0;
    idle(4);
    check("reg_rd_drained", 32'(exp_rv.size()), 32'd0);
    check("t1_run_held", 32'(cpu_run), 32'd1);
    check("value_o_held", 32'(value_o), 32'hEF);
    rd_dmem_check();

    // Partial final word gets zero-padded
    do_reset(1'b0);
    push_wr(0, 32'h44332211);
    push_wr(1, 32'h00006655);
    for (int i = 0; i < 6; i++) send_byte(prog2[i], i == 5);
    idle(2);
    check("t2_cpu_run", 32'(cpu_run), 32'd1);
    check("t2_writes_done", 32'(exp_wa.size()), 32'd0);

    // Gaps in load_valid mid-word
    do_reset(1'b0);
    push_wr(0, 32'h04030201);
    send_byte(8'h01, 1'b0);
    idle(1);
    send_byte(8'h02, 1'b0);
    send_byte(8'h03, 1'b0);
    idle(2);
    send_byte(8'h04, 1'b1);
    idle(2);
    check("t3_cpu_run", 32'(cpu_run), 32'd1);
    check("t3_writes_done", 32'(exp_wa.size()), 32'd0);

    // Reset mid-word aborts the load; a fresh load restarts at word 0
    do_reset(1'b0);
    send_byte(8'hAA, 1'b0);
    idle(1);
    send_byte(8'hBB, 1'b0);
    do_reset(1'b0);
    push_wr(0, 32'h8D7C6B5A);
    send_byte(8'h5A, 1'b0);
    send_byte(8'h6B, 1'b0);
    send_byte(8'h7C, 1'b0);
    send_byte(8'h8D, 1'b1);
    idle(2);
    check("t4_cpu_run", 32'(cpu_run), 32'd1);
    check("t4_writes_done", 32'(exp_wa.size()), 32'd0);

    // Overflow: 17 bytes into a 4-word memory
    do_reset(1'b0);
    push_wr(0, 32'h03020100);
    push_wr(1, 32'h07060504);
    push_wr(2, 32'h0B0A0908);
    push_wr(3, 32'h0F0E0D0C);
    for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b0);
    check("t5_ready_before_ovf", 32'(load_ready), 32'd1);
    send_byte(8'h10, 1'b0);
    check("t5_load_err", 32'(load_err), 32'd1);
    check("t5_load_ready", 32'(load_ready), 32'd0);
    load_valid = 1'b1;
    load_last = 1'b1;
    load_byte = 8'h77;
    idle(3);
    load_valid = 1'b0;
    load_last = 1'b0;
    idle(3);
    check("t5_err_sticky", 32'(load_err), 32'd1);
    check("t5_ready_low", 32'(load_ready), 32'd0);
    check("t5_cpu_run_low", 32'(cpu_run), 32'd0);
    check("t5_writes_done", 32'(exp_wa.size()), 32'd0);
    rd_dmem_check();
    do_reset(1'b0);
    check("t5_err_cleared", 32'(load_err), 32'd0);
    check("t5_ready_after_rst", 32'(load_ready), 32'd1);

    idle(3);
    check("final_wr_queue_empty", 32'(exp_wa.size()), 32'd0);
    check("final_rd_queue_empty", 32'(exp_rv.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/imem_loader_readback.md
Name: imem_loader_readback

Overview:
- Parametrised host-side bring-up port for the RISC-V core. It accepts a byte-serial program stream with a valid/ready handshake and packs bytes little-endian into XLEN-bit instruction words.
- It writes each packed word into instruction memory, then releases the core by asserting cpu_run.
- It also provides a pipelined byte-lane readback of the register file or data memory with a valid strobe. This replaces the free-running, un-handshaked instr_i / value_o scheme.

Parameters:
- XLEN, 32, word width; must be a multiple of 8.
- IMEM_DEPTH, 64, instruction memory depth in words.
- ADDR_W, 11, data-memory word address width.
- REG_ADDR_W, 5, register-file address width.
- Derived (localparam, not overridable): LANES = XLEN/8; LANE_W = clog2(LANES); IA_W = clog2(IMEM_DEPTH).

Ports:
- sys_clk  in  1  clock.
- sys_reset  in  1  synchronous, active-high reset.
- load_valid  in  1  load_byte is valid this cycle.
- load_byte  in  8  program byte.
- load_last  in  1  qualifies the final byte of the program.
- load_ready  out  1  loader can accept a byte.
- imem_we  out  1  instruction-memory write strobe.
- imem_waddr  out  IA_W  instruction word address.
- imem_wdata  out  XLEN  packed instruction word.
- cpu_run  out  1  core released from hold.
- load_err  out  1  sticky overflow flag.
- rd_req  in  1  readback request (single-cycle pulse).
- rd_sel  in  1  1 = register file, 0 = data memory.
- rd_addr  in  ADDR_W  word address; low REG_ADDR_W bits are used when rd_sel=1.
- rd_lane  in  LANE_W  byte lane, 0 = LSB.
- reg_raddr  out  REG_ADDR_W  register-file read address.
- dmem_raddr  out  ADDR_W  data-memory read address.
- reg_rdata  in  XLEN  register data, valid 1 cycle after reg_raddr.
- dmem_rdata  in  XLEN  memory data, valid 1 cycle after dmem_raddr.
- rd_valid  out  1  value_o is valid (1-cycle pulse).
- value_o  out  8  selected byte.

Behaviour:
- Single clock sys_clk; synchronous active-high reset sys_reset. All state is updated on the rising edge.
- Reset values:
  - State = LOAD; lane counter = 0; word pointer = 0; pack register = 0.
  - load_ready = 1; imem_we = 0; imem_waddr = 0; imem_wdata = 0.
  - cpu_run = 0; load_err = 0; rd_valid = 0; value_o = 0; readback pipeline cleared.
- Reset asserted mid-load or mid-readback aborts everything. Instruction-memory contents are not cleared; they are owned externally.
- A byte is accepted when load_valid && load_ready.
- FSM states: LOAD, FLUSH, RUN, FULL.
- LOAD:
  - An accepted byte goes into pack[8*lane +: 8] and lane increments.
  - On accepting lane LANES-1: next cycle imem_we=1 for exactly 1 cycle, imem_waddr = word pointer, imem_wdata = packed word. Then the pointer increments and lane/pack reset to 0.
  - Back-to-back bytes every cycle are sustained; load_ready stays 1.
  - Accepted byte with load_last=1 -> FLUSH; load_ready=0 from the next cycle.
  - Accepted byte while pointer == IMEM_DEPTH: byte dropped, no write, load_err set (sticky), go to FULL.
- FLUSH:
  - If the final byte completed a word, that write is the final write.
  - Otherwise the remaining lanes are zero-padded and the partial word is written (1 cycle).
  - The cycle after the final imem_we, go to RUN.
- RUN:
  - cpu_run = 1 and load_ready = 0; load_valid is ignored.
  - RUN is left only by reset.
- FULL:
  - load_ready = 0; cpu_run = 0; load_err = 1.
  - FULL is left only by reset.
- The pointer never wraps: IMEM_DEPTH words are written at most.
- load_last on a byte that overflows takes the FULL path, not FLUSH.
- Readback timing (fixed 2-cycle latency, valid in every FSM state):
  - Cycle 0: rd_req=1 samples rd_sel, rd_addr and rd_lane.
  - Cycle 1: reg_raddr / dmem_raddr are driven; both ports are always driven from the sampled address.
  - Cycle 2: the selected rdata's byte rd_lane is registered into value_o, and rd_valid=1 for one cycle.
- Requests may issue every cycle and are fully pipelined, one result per request, in order.
- value_o holds its value between requests.
- A request in the same cycle as reset is discarded.

Decomposition:
- Shared package:
  - FSM state enum (LOAD, FLUSH, RUN, FULL).
  - Readback-select constants RD_SEL_DMEM = 0 and RD_SEL_REG = 1.
  - Default XLEN.
- One natural sub-module: byte_lane_packer, holding the lane counter, pack register, zero-pad on flush, and word-complete strobe.
- The FSM and the readback pipeline stay in the top module.

Test Plan:
- Stream 8 bytes 13 05 A0 00 93 05 B0 00, load_last on the 8th, no gaps:
  - imem_we at waddr 0 with 0x00A00513, then waddr 1 with 0x00B00593.
  - cpu_run=1 two cycles after the last write; load_err=0.
- Stream 6 bytes (11 22 33 44 55 66, load_last on 0x66):
  - Words 0x44332211 then 0x00006655 are written; cpu_run follows.
- IMEM_DEPTH=4, send 17 bytes with no load_last:
  - 4 writes occur; the 17th byte is dropped.
  - load_err=1, load_ready=0, cpu_run=0 persist until reset.
- Toggle load_valid 1-0-1 with a mid-word gap:
  - Packing is correct (gaps are ignored).
  - Reset after 2 bytes, then a fresh 4-byte load writes at waddr 0.
- In RUN, with reg_rdata model x5 = 0xDEADBEEF:
  - Issue rd_req on 4 consecutive cycles, rd_sel=1, rd_addr=5, rd_lane 3, 2, 1, 0.
  - Results: value_o DE, AD, BE, EF on consecutive rd_valid pulses, first pulse 2 cycles after the first request.
- rd_sel=0, rd_addr=0x10, dmem model returns 0x12345678, lane 1:
  - dmem_raddr=0x10 at cycle 1; value_o=0x56 with rd_valid at cycle 2.
